// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master.
// Takes one read/write command on a valid/ready port, runs one bus cycle,
// waits for ack, err or a cycle-count timeout, and returns data plus status
// on a valid/ready response port. All bus and handshake outputs are registered.
module wb_cmd_master #(
  parameter  int BUS_DATA_WIDTH = 32,
  parameter  int BUS_ADDR_WIDTH = 8,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int BYTE_EN_WIDTH  = BUS_DATA_WIDTH / 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  // command port
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [BYTE_EN_WIDTH-1:0]  cmd_sel_i,
  // response port
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [BUS_DATA_WIDTH-1:0] rsp_dat_o,
  output logic                      rsp_err_o,
  output logic                      rsp_tmo_o,
  // Wishbone master
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [BYTE_EN_WIDTH-1:0]  wbm_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i
);

  // Wide enough to hold TIMEOUT_CYCLES itself, so the counter never wraps.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state_q;
  logic                      cmd_ready_q;
  logic                      cyc_q;
  logic                      we_q;
  logic [BYTE_EN_WIDTH-1:0]  sel_q;
  logic [BUS_ADDR_WIDTH-1:0] adr_q;
  logic [BUS_DATA_WIDTH-1:0] dat_q;
  logic                      rsp_valid_q;
  logic [BUS_DATA_WIDTH-1:0] rsp_dat_q;
  logic                      rsp_err_q;
  logic                      rsp_tmo_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_d;

  // Only advanced while below CNT_LAST, so the increment cannot overflow.
  assign cnt_d = cnt_q + CNT_ONE;

  // Command accept, bus cycle tracking with timeout, and response hold.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            sel_q       <= cmd_sel_i;
            cyc_q       <= 1'b1;
            cnt_q       <= CNT_ONE;
            cmd_ready_q <= 1'b0;
            state_q     <= BUS;
          end
        end
        BUS: begin
          // err beats ack; ack on the final counted cycle still beats timeout
          if (wbm_err_i) begin
            cyc_q       <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (wbm_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            cyc_q       <= 1'b0;
            rsp_tmo_q   <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_dat_q   <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule
